// File: rtl/kms_event_queue.sv
// Multi-source keyboard/mouse event queue: one register FIFO per source, drained by a
// round-robin arbiter into a single paced strobe/level stream.
module kms_event_queue #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned TYPE_W   = 2,
  parameter int unsigned GAP      = 7
) (
  input  logic                                           clk,
  input  logic                                           reset,
  input  logic [CHANNELS*DATA_W-1:0]                     in_data,
  input  logic [CHANNELS*TYPE_W-1:0]                     in_type,
  input  logic [CHANNELS-1:0]                            in_valid,
  output logic [CHANNELS-1:0]                            in_ready,
  input  logic                                           hold,
  output logic [DATA_W-1:0]                              out_data,
  output logic [TYPE_W-1:0]                              out_type,
  output logic                                           out_strobe,
  output logic                                           out_level,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] out_chan,
  output logic [CHANNELS-1:0]                            overflow,
  input  logic [CHANNELS-1:0]                            clr_overflow
);

  localparam int unsigned ChW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned GapW = (GAP > 0) ? $clog2(GAP + 1) : 1;

  logic [DATA_W-1:0] data_mem_q [CHANNELS][DEPTH];
  logic [TYPE_W-1:0] type_mem_q [CHANNELS][DEPTH];
  logic [PtrW-1:0]   wr_ptr_q   [CHANNELS];
  logic [PtrW-1:0]   rd_ptr_q   [CHANNELS];
  logic [CntW-1:0]   fill_q     [CHANNELS];

  logic [CHANNELS-1:0] push, drop, pop, not_empty;
  logic [ChW-1:0]      rr_q, rr_next, win;
  logic [ChW:0]        idx;
  logic                found, emit;
  logic [GapW-1:0]     gap_q;
  logic [DATA_W-1:0]   head_data, out_data_q;
  logic [TYPE_W-1:0]   head_type, out_type_q;
  logic [ChW-1:0]      out_chan_q;
  logic                out_strobe_q, out_level_q;
  logic [CHANNELS-1:0] overflow_q;

  // Full/empty decisions use the pre-pop fill level, so a same-cycle pop never frees a slot.
  always_comb begin
    in_ready  = '0;
    not_empty = '0;
    push      = '0;
    drop      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      in_ready[i]  = (fill_q[i] != CntW'(DEPTH));
      not_empty[i] = (fill_q[i] != '0);
      push[i]      = in_valid[i] & in_ready[i];
      drop[i]      = in_valid[i] & ~in_ready[i];
    end
  end

  always_comb begin
    win   = '0;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      idx = {1'b0, rr_q} + (ChW+1)'(k);
      if (idx >= (ChW+1)'(CHANNELS)) idx = idx - (ChW+1)'(CHANNELS);
      if (!found && not_empty[idx[ChW-1:0]]) begin
        found = 1'b1;
        win   = idx[ChW-1:0];
      end
    end
    emit = found && (gap_q == '0) && !hold;
    pop  = '0;
    if (emit) pop[win] = 1'b1;
    rr_next = (({1'b0, win} + (ChW+1)'(1)) == (ChW+1)'(CHANNELS)) ? '0 : win + ChW'(1);
    head_data = data_mem_q[win][rd_ptr_q[win]];
    head_type = type_mem_q[win][rd_ptr_q[win]];
  end

  // Storage carries no reset: pointers and fill levels define what is valid.
  always_ff @(posedge clk) begin
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (push[i]) begin
        data_mem_q[i][wr_ptr_q[i]] <= in_data[i*DATA_W +: DATA_W];
        type_mem_q[i][wr_ptr_q[i]] <= in_type[i*TYPE_W +: TYPE_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        fill_q[i]   <= '0;
      end
      rr_q         <= '0;
      gap_q        <= '0;
      out_data_q   <= '0;
      out_type_q   <= '0;
      out_chan_q   <= '0;
      out_strobe_q <= 1'b0;
      out_level_q  <= 1'b0;
      overflow_q   <= '0;
    end else begin
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
        fill_q[i] <= fill_q[i] + CntW'(push[i]) - CntW'(pop[i]);
      end
      // A new drop outranks a clear in the same cycle.
      overflow_q   <= drop | (overflow_q & ~clr_overflow);
      out_strobe_q <= emit;
      if (emit) begin
        out_data_q  <= head_data;
        out_type_q  <= head_type;
        out_chan_q  <= win;
        out_level_q <= ~out_level_q;
        rr_q        <= rr_next;
        gap_q       <= GapW'(GAP);
      end else if (gap_q != '0) begin
        gap_q <= gap_q - GapW'(1);
      end
    end
  end

  assign out_data   = out_data_q;
  assign out_type   = out_type_q;
  assign out_chan   = out_chan_q;
  assign out_strobe = out_strobe_q;
  assign out_level  = out_level_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_kms_event_queue.sv
// Bench for kms_event_queue: queue-level reference model for a GAP=7 instance plus
// directed back-to-back and hold checks on a GAP=0 instance.
module tb_kms_event_queue;

  localparam int C = 2;
  localparam int D = 8;
  localparam int G = 7;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_reset, a_hold, a_strobe, a_level;
  logic [15:0] a_data;
  logic [3:0]  a_type;
  logic [1:0]  a_valid, a_ready, a_ovf, a_clr, a_otype;
  logic [7:0]  a_odata;
  logic [0:0]  a_chan;

  logic        b_reset, b_hold, b_strobe, b_level;
  logic [15:0] b_data;
  logic [3:0]  b_type;
  logic [1:0]  b_valid, b_ready, b_ovf, b_clr, b_otype;
  logic [7:0]  b_odata;
  logic [0:0]  b_chan;

  kms_event_queue #(.CHANNELS(C), .DEPTH(D), .DATA_W(8), .TYPE_W(2), .GAP(G)) dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_data), .in_type(a_type), .in_valid(a_valid),
    .in_ready(a_ready), .hold(a_hold), .out_data(a_odata), .out_type(a_otype),
    .out_strobe(a_strobe), .out_level(a_level), .out_chan(a_chan), .overflow(a_ovf),
    .clr_overflow(a_clr)
  );

  kms_event_queue #(.CHANNELS(C), .DEPTH(D), .DATA_W(8), .TYPE_W(2), .GAP(0)) dut_b (
    .clk(clk), .reset(b_reset), .in_data(b_data), .in_type(b_type), .in_valid(b_valid),
    .in_ready(b_ready), .hold(b_hold), .out_data(b_odata), .out_type(b_otype),
    .out_strobe(b_strobe), .out_level(b_level), .out_chan(b_chan), .overflow(b_ovf),
    .clr_overflow(b_clr)
  );

  // Reference model state for dut_a: one event queue per channel, entries are {type, data}.
  logic [9:0] mq [C][$];
  int         m_rr, m_gap, m_chan;
  logic [7:0] m_data;
  logic [1:0] m_type;
  bit         m_strobe, m_level;
  bit   [1:0] m_ovf;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int got_data[$];
  int got_cyc[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic model_step();
    bit [1:0]   rdy;
    bit         found;
    int         w, j;
    logic [9:0] ev;
    if (a_reset) begin
      for (int i = 0; i < C; i++) mq[i].delete();
      m_rr = 0; m_gap = 0; m_chan = 0; m_data = '0; m_type = '0;
      m_strobe = 0; m_level = 0; m_ovf = '0;
    end else begin
      for (int i = 0; i < C; i++) rdy[i] = (mq[i].size() < D);
      found = 0;
      w = 0;
      for (int k = 0; k < C; k++) begin
        j = (m_rr + k) % C;
        if (!found && mq[j].size() != 0) begin
          found = 1;
          w = j;
        end
      end
      if (m_gap == 0 && !a_hold && found) begin
        ev = mq[w].pop_front();
        m_data = ev[7:0];
        m_type = ev[9:8];
        m_chan = w;
        m_strobe = 1;
        m_level = !m_level;
        m_rr = (w + 1) % C;
        m_gap = G;
      end else begin
        m_strobe = 0;
        if (m_gap > 0) m_gap--;
      end
      for (int i = 0; i < C; i++) begin
        if (a_valid[i] && rdy[i]) mq[i].push_back({a_type[i*2 +: 2], a_data[i*8 +: 8]});
        m_ovf[i] = (a_valid[i] && !rdy[i]) || (m_ovf[i] && !a_clr[i]);
      end
    end
  endtask

  task automatic compare_a();
    logic [1:0] exp_ready;
    for (int i = 0; i < C; i++) exp_ready[i] = (mq[i].size() < D);
    check("strobe", a_strobe, m_strobe);
    check("level", a_level, m_level);
    check("data", a_odata, m_data);
    check("type", a_otype, m_type);
    check("chan", a_chan, m_chan);
    check("ready", a_ready, exp_ready);
    check("overflow", a_ovf, m_ovf);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    @(negedge clk);
    compare_a();
    if (a_strobe) begin
      got_data.push_back(a_odata);
      got_cyc.push_back(cyc);
    end
  endtask

  task automatic reset_a();
    a_reset = 1'b1;
    tick();
    a_reset = 1'b0;
  endtask

  task automatic clear_got();
    got_data.delete();
    got_cyc.delete();
  endtask

  initial begin
    a_reset = 1'b1; a_hold = 1'b0; a_data = '0; a_type = '0; a_valid = '0; a_clr = '0;
    b_reset = 1'b1; b_hold = 1'b0; b_data = '0; b_type = '0; b_valid = '0; b_clr = '0;
    repeat (3) tick();
    check("rst_ready", a_ready, 2'b11);
    check("rst_strobe", a_strobe, 0);
    check("rst_level", a_level, 0);
    check("rst_ovf", a_ovf, 0);
    check("rst_ready_b", b_ready, 2'b11);
    a_reset = 1'b0;
    b_reset = 1'b0;
    repeat (6) tick();

    // Single event on ch0
    a_valid = 2'b01; a_data = 16'h0045; a_type = 4'b0001;
    tick();
    check("se_early", a_strobe, 0);
    a_valid = '0;
    tick();
    check("se_strobe", a_strobe, 1);
    check("se_data", a_odata, 8'h45);
    check("se_type", a_otype, 1);
    check("se_chan", a_chan, 0);
    check("se_level", a_level, 1);
    tick();
    check("se_pulse", a_strobe, 0);
    repeat (10) tick();

    // Fairness: 4 events per channel queued before the first emission
    reset_a();
    a_hold = 1'b1;
    for (int k = 0; k < 4; k++) begin
      a_valid = 2'b11;
      a_data = {8'(32'h20 + k), 8'(32'h10 + k)};
      tick();
    end
    a_valid = '0;
    clear_got();
    a_hold = 1'b0;
    repeat (70) tick();
    check("fair_count", got_data.size(), 8);
    for (int i = 0; i < got_data.size() && i < 8; i++) begin
      check("fair_order", got_data[i], (i % 2 == 0) ? 32'h10 + i / 2 : 32'h20 + i / 2);
      if (i > 0) check("fair_spacing", got_cyc[i] - got_cyc[i-1], 8);
    end
    check("fair_level", a_level, 0);

    // Overflow: 10 pushes into an 8-deep channel while held
    reset_a();
    a_hold = 1'b1;
    for (int k = 0; k < 10; k++) begin
      a_valid = 2'b10;
      a_data = {8'(32'h30 + k), 8'h00};
      tick();
      if (k == 6) check("ovf_ready7", a_ready[1], 1);
      if (k == 7) check("ovf_ready8", a_ready[1], 0);
    end
    a_valid = '0;
    check("ovf_set", a_ovf, 2'b10);
    clear_got();
    a_hold = 1'b0;
    repeat (75) tick();
    check("ovf_count", got_data.size(), 8);
    for (int i = 0; i < got_data.size() && i < 8; i++) check("ovf_order", got_data[i], 32'h30 + i);
    a_clr = 2'b10;
    tick();
    a_clr = '0;
    check("ovf_clear", a_ovf, 2'b00);

    // Push to a full channel in its own pop cycle, then drop and clear together
    reset_a();
    a_hold = 1'b1;
    for (int k = 0; k < 8; k++) begin
      a_valid = 2'b01;
      a_data = {8'h00, 8'(32'h40 + k)};
      tick();
    end
    a_hold = 1'b0;
    a_valid = 2'b01;
    a_data = 16'h004f;
    tick();
    a_valid = '0;
    a_hold = 1'b1;
    check("pp_ovf", a_ovf[0], 1);
    check("pp_ready", a_ready[0], 1);
    a_clr = 2'b01;
    tick();
    a_clr = '0;
    check("pp_clear", a_ovf[0], 0);
    a_valid = 2'b01;
    a_data = 16'h0048;
    tick();
    check("pp_full", a_ready[0], 0);
    a_clr = 2'b01;
    tick();
    a_valid = '0;
    a_clr = '0;
    check("set_wins", a_ovf[0], 1);
    clear_got();
    a_hold = 1'b0;
    repeat (75) tick();
    check("pp_count", got_data.size(), 8);
    for (int i = 0; i < got_data.size() && i < 8; i++) check("pp_order", got_data[i], 32'h41 + i);

    // Reset with events queued and an emission due
    reset_a();
    a_hold = 1'b1;
    for (int k = 0; k < 5; k++) begin
      a_valid = 2'b01;
      a_data = {8'h00, 8'(32'h70 + k)};
      tick();
    end
    a_valid = '0;
    a_hold = 1'b0;
    a_reset = 1'b1;
    tick();
    check("mr_strobe", a_strobe, 0);
    check("mr_data", a_odata, 0);
    check("mr_level", a_level, 0);
    check("mr_chan", a_chan, 0);
    check("mr_ready", a_ready, 2'b11);
    a_reset = 1'b0;
    clear_got();
    a_valid = 2'b01;
    a_data = 16'h007a;
    tick();
    a_valid = '0;
    tick();
    check("rel_strobe", a_strobe, 1);
    check("rel_data", a_odata, 8'h7a);
    repeat (10) tick();
    check("mr_discard", got_data.size(), 1);

    // Randomised traffic against the model
    reset_a();
    repeat (3000) begin
      for (int i = 0; i < C; i++) begin
        a_valid[i] = ($urandom_range(99) < 35);
        a_clr[i]   = ($urandom_range(99) < 5);
      end
      a_data  = 16'($urandom);
      a_type  = 4'($urandom);
      a_hold  = ($urandom_range(99) < 20);
      a_reset = ($urandom_range(999) < 3);
      tick();
    end
    a_valid = '0; a_clr = '0; a_hold = 1'b0; a_reset = 1'b0;
    repeat (5) tick();

    // GAP=0 instance: back-to-back strobes
    b_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_valid = 2'b01;
      b_data = {8'h00, 8'(32'h50 + k)};
      tick();
    end
    b_valid = '0;
    b_hold = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b2b_strobe", b_strobe, 1);
      check("b2b_data", b_odata, 32'h50 + i);
      check("b2b_level", b_level, (i % 2 == 0) ? 1 : 0);
    end
    tick();
    check("b2b_end", b_strobe, 0);

    // GAP=0 instance: hold raised between first and second emission
    b_hold = 1'b1;
    for (int k = 0; k < 3; k++) begin
      b_valid = 2'b01;
      b_data = {8'h00, 8'(32'h60 + k)};
      tick();
    end
    b_valid = '0;
    b_hold = 1'b0;
    tick();
    check("hold_first", b_strobe, 1);
    check("hold_first_data", b_odata, 8'h60);
    b_hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("hold_quiet", b_strobe, 0);
    end
    b_hold = 1'b0;
    for (int i = 1; i < 3; i++) begin
      tick();
      check("hold_resume", b_strobe, 1);
      check("hold_resume_data", b_odata, 32'h60 + i);
    end
    tick();
    check("hold_end", b_strobe, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/kms_event_queue.md
# kms_event_queue

Parametrised multi-source input-event queue between the host-side user I/O block and the minimig keyboard/mouse interface. Each of `CHANNELS` sources (keyboard, mouse, extra HID ports) gets its own FIFO. A round-robin arbiter drains the FIFOs into a single paced stream of `kbd_mouse_data` / `kbd_mouse_type` / `kbd_mouse_strobe` / `kms_level`. It replaces the single-register hand-off, adding buffering, fairness, back-pressure and overflow reporting.

## Interface
Parameters:
- `CHANNELS`, 2: number of event sources; 1..8.
- `DEPTH`, 8: entries per channel FIFO; power of two, 2..64.
- `DATA_W`, 8: event payload width.
- `TYPE_W`, 2: event type width.
- `GAP`, 7: minimum idle cycles between two output strobes; 0 allows back-to-back strobes.

Ports:
- `clk`  in  1  core clock (clk_28 domain); the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  CHANNELS*DATA_W  payload; channel i at bits [i*DATA_W +: DATA_W].
- `in_type`  in  CHANNELS*TYPE_W  type; channel i at bits [i*TYPE_W +: TYPE_W].
- `in_valid`  in  CHANNELS  push request per channel.
- `in_ready`  out  CHANNELS  channel FIFO not full (combinational from fill level).
- `hold`  in  1  sink busy; no new emission starts while high.
- `out_data`  out  DATA_W  emitted payload (to `kbd_mouse_data`).
- `out_type`  out  TYPE_W  emitted type (to `kbd_mouse_type`).
- `out_strobe`  out  1  one-cycle pulse per emitted event.
- `out_level`  out  1  toggles once per emitted event (to `kms_level`).
- `out_chan`  out  clog2(CHANNELS) (min 1)  source channel of the current output.
- `overflow`  out  CHANNELS  sticky per channel: an event was dropped.
- `clr_overflow`  in  CHANNELS  clears the matching `overflow` bit.

## Operation
- **Push.** Channel i accepts when `in_valid[i] & in_ready[i]`. Data and type are written at the write pointer, and the pointer increments modulo `DEPTH`.
- **Full channel.** `in_valid[i]` while the FIFO is full drops the event and sets `overflow[i]`. The full test uses the pre-pop fill level, so a push to a full channel is dropped even when the same channel pops in that cycle.
- **Fill counters.** Each fill counter is clog2(DEPTH)+1 bits, range 0..DEPTH. A simultaneous push and pop on a non-full channel leaves the fill level unchanged.
- **Arbiter.** Round-robin pointer `rr`. Candidates are scanned from channel `rr`, wrapping upward. The first non-empty channel wins, and `rr` is then set to winner+1 modulo `CHANNELS`.
- **Emission conditions.** An emission needs `gap_cnt==0`, `hold==0`, and at least one non-empty channel.
- **Emission cycle.** The winner pops and its head entry is registered into `out_data`/`out_type`/`out_chan`. In the next cycle `out_strobe`=1 and `out_level` inverts.
- **Gap counter.** Loaded with `GAP` at emission, then decrements by 1 per cycle down to 0. While it is non-zero, no emission occurs.
- **Output hold.** `out_data`/`out_type`/`out_chan` keep their values until the next emission.
- **`hold`.** Only blocks new emissions; it never cancels a strobe already scheduled.
- **Clear vs. set.** `clr_overflow[i]` in the same cycle as a new drop on channel i leaves the bit set (set wins).
- **Reset.** Asserting `reset` mid-operation discards all queued events and any pending strobe.

## Timing
- **Reset values.** All FIFOs empty, so `in_ready` = all ones. `out_data`=0, `out_type`=0, `out_chan`=0, `out_strobe`=0, `out_level`=0, `overflow`=0, `gap_cnt`=0, `rr`=0.
- **Latency.** Push at cycle N makes the FIFO non-empty at N+1. With the sink idle, emission is at N+1 and `out_strobe` rises at N+2.
- **Throughput.** At most one event per GAP+1 cycles. With `GAP`=0, a continuously busy queue strobes every cycle.
- **Release after reset.** The cycle after `reset` deasserts, pushes are accepted.
- **FIFO storage.** Register based; no RAM read latency is allowed to change the figures above.

## Test plan
- **Single event.** CHANNELS=2, GAP=7. Push ch0 data 0x45 type 1 at cycle 10 -> `out_strobe` at cycle 12 with `out_data`=0x45, `out_type`=1, `out_chan`=0; `out_level` goes 0->1.
- **Fairness.** Fill ch0 and ch1 with 4 events each (ch0 0x10..0x13, ch1 0x20..0x23) before the first emission -> output order 0x10, 0x20, 0x11, 0x21, ...; strobes are exactly 8 cycles apart; `out_level` ends at 0.
- **Overflow.** DEPTH=8, `hold`=1. Push 10 events on ch1 -> `in_ready[1]` low after the 8th; `overflow[1]`=1; after `hold` drops, exactly 8 events emerge in order. Pulse `clr_overflow[1]` -> `overflow[1]`=0.
- **Hold and gap.** GAP=0: 3 queued events give strobes on 3 consecutive cycles. Raising `hold` between the 1st and 2nd emission -> no strobe while `hold` is high; the remaining events follow after release.
- **Mid-operation reset.** Assert `reset` with 5 events queued and a strobe pending -> no strobe in the following cycle; all outputs at their reset values; `in_ready` all ones.
- **Same-cycle push/pop and drop/clear.** Push to a full channel that pops in the same cycle -> event dropped and `overflow` set. Drop and `clr_overflow` in the same cycle -> `overflow` stays 1.
